// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BASE = 32'h8000_0000;

  function automatic logic [31:0] mask_expand(input logic [3:0] m);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{m[i]}};
    return bm;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with byte-enable writes and a registered read port.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;
  logic [31:0] bm;

  assign bm    = mask_expand(be);
  assign rdata = rdata_q;

  // Read data only moves on a load, so it holds while the response is stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= (mem[addr] & ~bm) | (wdata & bm);
      else    rdata_q   <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding load/store, fixed latency, valid/ready both ways.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE       = DEF_BASE,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wen_q, wen_d, inr_q, inr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rd_sel_q, rd_sel_d;

  logic [31:0]     diff;
  logic [AW-1:0]   req_idx;
  logic            req_inr;
  logic            go_resp, commit_ok, commit_wen;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata, ram_rdata;
  logic [3:0]      ram_be;
  logic            unused_ok;

  // Full 32-bit difference: addresses below BASE wrap to huge values and fail the check.
  assign diff      = req_addr - BASE;
  assign req_idx   = diff[AW+1:2];
  assign req_inr   = (diff[31:AW+2] == '0);
  assign unused_ok = ^diff[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    inr_d       = inr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_sel_d    = rd_sel_q;
    go_resp     = 1'b0;
    commit_ok   = inr_q;
    commit_wen  = wen_q;
    ram_addr    = idx_q;
    ram_wdata   = wdata_q;
    ram_be      = wmask_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        wen_d   = req_wen;
        inr_d   = req_inr;
        idx_d   = req_idx;
        wdata_d = req_wdata;
        wmask_d = req_wmask;
        if (LATENCY == 1) begin
          go_resp    = 1'b1;
          commit_ok  = req_inr;
          commit_wen = req_wen;
          ram_addr   = req_idx;
          ram_wdata  = req_wdata;
          ram_be     = req_wmask;
        end else begin
          state_d     = S_WAIT;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: if (rsp_ready) begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_sel_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Entry into RESP is the only RAM access point, so a reset in WAIT drops the store.
    if (go_resp) begin
      state_d     = S_RESP;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~commit_ok;
      rd_sel_d    = commit_ok & ~commit_wen;
    end
    ram_en = go_resp & commit_ok;
    ram_we = commit_wen;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wen_q       <= 1'b0;
      inr_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      inr_q       <= inr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  mem_responder_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: vector table on a LATENCY=2 instance, corner sequences on LATENCY=4.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rv_a, rr_a, wen_a, pv_a, prdy_a, perr_a;
  logic [31:0] addr_a, wd_a, prd_a;
  logic [3:0]  wm_a;
  logic        rst_b, rv_b, rr_b, wen_b, pv_b, prdy_b, perr_b;
  logic [31:0] addr_b, wd_b, prd_b;
  logic [3:0]  wm_b;

  mem_responder #(.LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(rv_a), .req_ready(rr_a), .req_wen(wen_a),
    .req_addr(addr_a), .req_wdata(wd_a), .req_wmask(wm_a), .rsp_valid(pv_a),
    .rsp_ready(prdy_a), .rsp_rdata(prd_a), .rsp_err(perr_a)
  );

  mem_responder #(.LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(rv_b), .req_ready(rr_b), .req_wen(wen_b),
    .req_addr(addr_b), .req_wdata(wd_b), .req_wmask(wm_b), .rsp_valid(pv_b),
    .rsp_ready(prdy_b), .rsp_rdata(prd_b), .rsp_err(perr_b)
  );

  int   checks = 0;
  int   errors = 0;
  logic sel = 1'b0;

  logic        o_rr, o_pv, o_err;
  logic [31:0] o_rd;
  assign o_rr  = sel ? rr_b   : rr_a;
  assign o_pv  = sel ? pv_b   : pv_a;
  assign o_err = sel ? perr_b : perr_a;
  assign o_rd  = sel ? prd_b  : prd_a;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    if (sel) begin rv_b = v; wen_b = w; addr_b = a; wd_b = d; wm_b = m; end
    else     begin rv_a = v; wen_a = w; addr_a = a; wd_a = d; wm_a = m; end
  endtask

  task automatic set_prdy(input logic r);
    if (sel) prdy_b = r; else prdy_a = r;
  endtask

  // One full transaction; hold > 0 stalls the response that many cycles.
  task automatic txn(input string name, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic exp_err,
                     input logic [31:0] exp_rd, input int lat, input int hold);
    int k;
    @(negedge clk);
    chk({name, " req_ready"}, 32'(o_rr), 32'd1);
    set_req(1'b1, w, a, d, m);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    k = 1;
    while (!o_pv && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, 32'(k), 32'(lat));
    chk({name, " err"}, 32'(o_err), 32'(exp_err));
    chk({name, " rdata"}, o_rd, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 32'(o_pv), 32'd1);
      chk({name, " hold rdata"}, o_rd, exp_rd);
      chk({name, " hold err"}, 32'(o_err), 32'(exp_err));
      chk({name, " hold ready"}, 32'(o_rr), 32'd0);
    end
    set_prdy(1'b1);
    @(negedge clk);
    set_prdy(1'b0);
    chk({name, " retire valid"}, 32'(o_pv), 32'd0);
    chk({name, " retire ready"}, 32'(o_rr), 32'd1);
    chk({name, " retire rdata"}, o_rd, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD};
    tbl[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
    tbl[10] = '{1'b1, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[12] = '{1'b1, 32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D};
    tbl[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h8, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 1'b0, 32'hFFBB_33DD};

    rst_a = 1'b0; rst_b = 1'b0;
    rv_a = 0; wen_a = 0; addr_a = 0; wd_a = 0; wm_a = 0; prdy_a = 0;
    rv_b = 0; wen_b = 0; addr_b = 0; wd_b = 0; wm_b = 0; prdy_b = 0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(rr_a), 32'd1);
    chk("reset valid", 32'(pv_a), 32'd0);
    chk("reset rdata", prd_a, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle ready", 32'(rr_a), 32'd1);
      chk("idle valid", 32'(pv_a), 32'd0);
      chk("idle err", 32'(perr_a), 32'd0);
    end

    sel = 1'b0;
    for (int i = 0; i < NV; i++)
      txn($sformatf("v%0d", i), tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
          tbl[i].exp_err, tbl[i].exp_rd, 2, 0);

    txn("bp", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 2, 5);

    sel = 1'b1;
    txn("pre", 1'b1, 32'h8000_0030, 32'h0102_0304, 4'hF, 1'b0, 32'h0, 4, 0);
    @(negedge clk);
    set_req(1'b1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("wait ready", 32'(rr_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midwait valid", 32'(pv_b), 32'd0);
    chk("midwait ready", 32'(rr_b), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("post rst valid", 32'(pv_b), 32'd0);
    txn("after", 1'b0, 32'h8000_0030, 32'h0, 4'h0, 1'b0, 32'h0102_0304, 4, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store requests. It is the slave end of the data-memory interface that the core drives as initiator.
- Holds a word-organised RAM mapped at BASE. It accepts one request at a time over a valid/ready request channel and returns read data or write acknowledgement over a valid/ready response channel after a programmable latency.
- Replaces the zero-latency behavioural memory path, so the core's LSU can be exercised against realistic handshakes.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB)
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored (word aligned)
- req_wdata  in  32  store data
- req_wmask  in  4  byte-lane write enables, bit i enables wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  address outside [BASE, BASE + 4*2^DEPTH_LOG2)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept occurs on an edge E0 where req_valid && req_ready. At that edge, latch wen, word index = (addr - BASE) >> 2, wdata, wmask and the range-check result.
  - If LATENCY = 1, go directly to RESP at E0. Otherwise go to WAIT with counter = LATENCY - 2.
- WAIT:
  - req_ready = 0.
  - Counter decrements each edge. On the edge where the counter equals 0, go to RESP.
  - rsp_valid therefore first becomes high after edge E0 + LATENCY - 1.
- On the edge entering RESP:
  - Load, in range: rsp_rdata = RAM[index].
  - Store, in range: each enabled byte lane is written; rsp_rdata = 0.
  - Out of range: no RAM access; rsp_rdata = 0; rsp_err = 1.
  - This entry edge is the single commit point for stores.
- RESP:
  - rsp_valid = 1, req_ready = 0.
  - rsp_rdata and rsp_err hold stable until the handshake.
  - On an edge with rsp_ready = 1: go to IDLE, and clear rsp_valid, rsp_rdata and rsp_err.
  - Backpressure of any length is legal.
- Throughput: one outstanding request. The earliest next accept is the cycle after the response handshake, so minimum occupancy is LATENCY + 1 cycles per request.
- Request signals are don't-care while req_ready = 0. Requests are never queued.
- wmask = 0 on a store: no bytes change, and a normal (non-error) response is still returned.
- Index arithmetic: the subtraction is 32-bit. The range check uses the full 32-bit difference, so addresses below BASE that wrap are out of range.
- Reset mid-operation:
  - In WAIT: the pending store is discarded and RAM is unchanged.
  - In RESP: the store has already committed; only the response is dropped.
- Read-after-write: a load accepted after a store's response observes the new data.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/WAIT/RESP as a 2-bit enum)
  - default BASE constant
  - byte-mask expansion function (4-bit mask to 32-bit bit mask)
- One sub-module, mem_responder_ram:
  - single-port synchronous RAM, 2^DEPTH_LOG2 x 32
  - byte-enable write, registered read
  - keeps storage inferable and replaceable by a DPI-backed model

Test Plan:
- Reset then idle: rst low for 3 cycles, release -> req_ready = 1, rsp_valid = 0, rsp_err = 0 every cycle; no response ever appears without a request.
- Store then load, LATENCY = 2: store addr 32'h8000_0010, wdata 32'hDEADBEEF, wmask 4'hF; then load same addr -> store response has rsp_err = 0 and rsp_rdata = 0, rsp_valid rises 1 edge after accept; load returns 32'hDEADBEEF.
- Byte mask: preload 32'h11223344 at 32'h8000_0020; store wdata 32'hAABBCCDD with wmask 4'b0101 -> subsequent load returns 32'h11BB33DD.
- Out of range: load 32'h7FFF_FFFC and 32'h8000_4000 -> rsp_err = 1, rsp_rdata = 0. Store to 32'h8000_4000 leaves RAM word 0 unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; response retires on the first rsp_ready = 1 edge; req_ready returns 1 the next cycle.
- Reset mid-WAIT (LATENCY = 4): store 32'hCAFEF00D to 32'h8000_0030, assert rst 1 cycle after accept -> rsp_valid = 0 immediately; a later load from 32'h8000_0030 returns the prior contents, not 32'hCAFEF00D.
